// File: rtl/debayer_line_ctrl.sv
// Line sequencer for the 4-line RAM debayer: rotates the RAM write select and read
// focus, addresses words within a line, and tracks line parity, fill level and length errors.
module debayer_line_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 11,
    parameter int MAX_WORDS  = 2047
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  frame_start_i,
    input  logic                  line_valid_i,
    input  logic                  data_valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [3:0]            wr_en_o,
    output logic [ADDR_WIDTH-1:0] line_addr_o,
    output logic [1:0]            rd_idx_o,
    output logic                  line_parity_o,
    output logic                  output_en_o,
    output logic [ADDR_WIDTH-1:0] line_words_o,
    output logic                  overflow_err_o,
    output logic                  length_err_o,
    output logic [1:0]            state_o
);

    // Handshake: data_valid_i qualifies data_i for one cycle with no backpressure; a word is
    // taken only while line_valid_i is high inside an accepted line, otherwise it is dropped.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(MAX_WORDS);

    logic [1:0]            state, state_nxt;
    logic [3:0]            wr_sel, wr_sel_nxt;
    logic [1:0]            rd_idx_nxt;
    logic [1:0]            line_count, line_count_nxt;
    logic                  parity_nxt;
    logic                  lv_q;
    logic                  line_act, line_act_nxt;
    logic                  lines_done, lines_done_nxt;
    logic [ADDR_WIDTH-1:0] word_cnt, word_cnt_nxt;
    logic [ADDR_WIDTH-1:0] line_words_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  ovf_nxt, len_nxt;
    logic                  line_start, line_end, active, wr_ok, first_line;

    assign state_o = state;

    always_comb begin
        line_start     = line_valid_i & ~lv_q;
        line_end       = ~line_valid_i & lv_q;
        state_nxt      = state;
        wr_sel_nxt     = wr_sel;
        rd_idx_nxt     = rd_idx_o;
        line_count_nxt = line_count;
        parity_nxt     = line_parity_o;
        line_act_nxt   = line_act;
        lines_done_nxt = lines_done;
        word_cnt_nxt   = word_cnt;
        line_words_nxt = line_words_o;
        ovf_nxt        = overflow_err_o;
        len_nxt        = length_err_o;
        wr_addr        = word_cnt;
        wr_ok          = 1'b0;
        first_line     = 1'b0;

        // Frame reset is applied first so a coincident line start counts as line one.
        if (frame_start_i) begin
            state_nxt      = ST_FILL;
            wr_sel_nxt     = 4'b1000;
            rd_idx_nxt     = 2'b01;
            line_count_nxt = 2'd0;
            parity_nxt     = 1'b0;
            line_act_nxt   = 1'b0;
            lines_done_nxt = 1'b0;
            ovf_nxt        = 1'b0;
            len_nxt        = 1'b0;
        end
        active = (state_nxt != ST_IDLE);

        if (active && line_end && line_act_nxt) begin
            line_act_nxt   = 1'b0;
            line_words_nxt = word_cnt;
            if (lines_done_nxt && (word_cnt != line_words_o))
                len_nxt = 1'b1;
            lines_done_nxt = 1'b1;
        end

        if (active && line_start) begin
            first_line     = (line_count_nxt == 2'd0);
            wr_sel_nxt     = {wr_sel_nxt[2:0], wr_sel_nxt[3]};
            rd_idx_nxt     = rd_idx_nxt + 2'd1;
            if (line_count_nxt != 2'd3)
                line_count_nxt = line_count_nxt + 2'd1;
            parity_nxt     = first_line ? 1'b1 : ~parity_nxt;
            word_cnt_nxt   = '0;
            line_act_nxt   = 1'b1;
            if (line_count_nxt == 2'd3)
                state_nxt = ST_RUN;
        end

        if (active && line_act_nxt && line_valid_i && data_valid_i) begin
            wr_addr = word_cnt_nxt;
            if (word_cnt_nxt == MAX_CNT) begin
                ovf_nxt = 1'b1;
            end else begin
                wr_ok        = 1'b1;
                word_cnt_nxt = word_cnt_nxt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state          <= ST_IDLE;
            wr_sel         <= 4'b1000;
            rd_idx_o       <= 2'b01;
            line_count     <= 2'd0;
            line_parity_o  <= 1'b0;
            lv_q           <= 1'b0;
            line_act       <= 1'b0;
            lines_done     <= 1'b0;
            word_cnt       <= '0;
            line_words_o   <= '0;
            overflow_err_o <= 1'b0;
            length_err_o   <= 1'b0;
            wr_en_o        <= 4'b0000;
            line_addr_o    <= '0;
            data_o         <= '0;
            output_en_o    <= 1'b0;
        end else begin
            state          <= state_nxt;
            wr_sel         <= wr_sel_nxt;
            rd_idx_o       <= rd_idx_nxt;
            line_count     <= line_count_nxt;
            line_parity_o  <= parity_nxt;
            lv_q           <= line_valid_i;
            line_act       <= line_act_nxt;
            lines_done     <= lines_done_nxt;
            word_cnt       <= word_cnt_nxt;
            line_words_o   <= line_words_nxt;
            overflow_err_o <= ovf_nxt;
            length_err_o   <= len_nxt;
            wr_en_o        <= wr_ok ? wr_sel_nxt : 4'b0000;
            if (wr_ok)
                line_addr_o <= wr_addr;
            data_o         <= data_i;
            output_en_o    <= (state_nxt == ST_RUN);
        end
    end

endmodule

// File: doc/debayer_line_ctrl.md
Name: debayer_line_ctrl

Overview:
- Synchronous sequencer for the 4-line RAM debayer datapath. It replaces edge-clocked line bookkeeping with a single-clock FSM.
- Generates the one-hot line-RAM write selects, a shared read/write word address, the rotating read focus index, the line parity and the output-enable gate.
- Sits between the RAW depacker output and the debayer line RAMs, on the MIPI byte clock domain.
- Flags over-long lines and line-length changes within a frame.

Parameters:
DATA_WIDTH, 64, width of the pixel word passed through (4 x 16-bit pixels)
ADDR_WIDTH, 11, line RAM address width
MAX_WORDS, 2047, maximum words per line; words at or beyond this address are dropped

Ports:
clk_i  input  1  byte clock; all logic on rising edge
reset_n_i  input  1  synchronous active-low reset
frame_start_i  input  1  one-cycle pulse at CSI frame start
line_valid_i  input  1  high for the duration of a line
data_valid_i  input  1  data_i word valid this cycle
data_i  input  DATA_WIDTH  pixel word from depacker
data_o  output  DATA_WIDTH  data_i delayed 1 cycle, aligned with wr_en_o and line_addr_o
wr_en_o  output  4  one-hot per-RAM write enable (wr_sel AND registered data_valid)
line_addr_o  output  ADDR_WIDTH  RAM write/read address for data_o
rd_idx_o  output  2  index of the line RAM in read focus
line_parity_o  output  1  0 = even line (BGGR G/B row), 1 = odd line
output_en_o  output  1  high when 3 or more lines are buffered; gates debayer output_valid
line_words_o  output  ADDR_WIDTH  word count of the last completed line
overflow_err_o  output  1  sticky: a line exceeded MAX_WORDS
length_err_o  output  1  sticky: a line length differed from the previous line in this frame

Behaviour:
- Reset, checked only on clk_i edges while reset_n_i = 0:
  - state=IDLE, wr_sel=4'b1000, rd_idx_o=2'b01, line_count=0, line_parity_o=0.
  - wr_en_o=0, line_addr_o=0, data_o=0, output_en_o=0, line_words_o=0, both error flags 0, lv_q=0.
  - Reset mid-line discards the line; nothing resumes until the next frame_start_i.
- line_start = line_valid_i & ~lv_q, where lv_q is line_valid_i registered.
- line_end = ~line_valid_i & lv_q.
- FSM states:
  - IDLE: all inputs ignored except frame_start_i, which moves to FILL.
  - FILL: line_count < 3.
  - RUN: line_count == 3.
- frame_start_i, accepted in any state (including mid-line):
  - Next cycle: wr_sel=4'b1000, rd_idx=01, line_count=0, parity=0, both error flags cleared, state=FILL.
  - An in-progress line is abandoned; its remaining words are dropped until the next line_start.
- line_start while in FILL/RUN, taking effect the next cycle:
  - wr_sel rotates left by 1 (1000 -> 0001).
  - rd_idx increments mod 4.
  - line_count increments, saturating at 3.
  - parity toggles, except on the first line of a frame, where parity is 1 (first line is odd).
  - Word counter is cleared.
  - FILL -> RUN when line_count becomes 3.
- frame_start_i and line_start in the same cycle: the frame reset is applied first, then the line start is counted. Next cycle shows wr_sel=0001, rd_idx=10, line_count=1, parity=1.
- Write path: on each cycle with line_valid_i & data_valid_i in FILL/RUN and word counter < MAX_WORDS:
  - Next cycle: data_o=data_i, line_addr_o=word counter, wr_en_o=wr_sel (using the post-rotation value if this is also the line_start cycle).
  - Word counter increments.
- data_valid_i is accepted on the line_start cycle and is written at address 0 of the new RAM.
- data_valid_i with line_valid_i low is ignored: wr_en_o=0.
- Overflow: a valid word arriving with word counter == MAX_WORDS is dropped (wr_en_o=0) and overflow_err_o is set sticky. The counter does not wrap.
- line_end:
  - Next cycle: line_words_o = word counter, saturated at MAX_WORDS.
  - If at least one line of this frame has completed before and the new count differs from the previous line_words_o, length_err_o is set sticky.
- output_en_o = registered (state==RUN). It rises one cycle after the third line_start of the frame.
- wr_en_o is never more than one bit hot.
- The RAM currently being written is never the rd_idx focus RAM's neighbour set, i.e. rd_idx != index of wr_sel-1 after rotation. The bench checks this by assertion.
- Latency: data_i to data_o/wr_en_o is 1 cycle. line_start to updated selects is 1 cycle.

Test Plan:
- Reset, then frame_start_i, then 4 lines of 8 words each -> wr_en_o hot bits 0001, 0010, 0100, 1000. line_addr_o runs 0..7 each line. line_words_o = 8 after each line. output_en_o is high starting 1 cycle after the 3rd line_start.
- frame_start_i coincident with line_start -> next cycle wr_sel=0001, rd_idx=2, line_count=1, parity=1. The first word is written at address 0.
- Line of MAX_WORDS+3 valid words (MAX_WORDS overridden to 16) -> exactly 16 writes at addresses 0..15 and overflow_err_o=1. The flag stays set through the next line and clears on the next frame_start_i.
- Lines of 8, 8, then 6 words -> length_err_o rises 1 cycle after the third line_end, and line_words_o = 6.
- reset_n_i asserted for 1 cycle at word 4 of line 2 -> all outputs return to their reset values. line_valid/data_valid are ignored until frame_start_i, with no wr_en_o pulses in between.
- Gapped data_valid_i (1-0-1 pattern) with line_valid_i high, plus data_valid_i pulses between lines -> addresses are contiguous, and no writes occur while line_valid_i is low.
